// File: rtl/servo_pwm_scheduler.sv
`timescale 1ns/1ps
// Purpose : time-multiplexed servo PWM sequencer; one channel pulsed per slot inside a fixed frame.
// Latency : pwm_out is registered, so a pulse rises one cycle after its slot starts; frame_start/update_ack/busy are decoded from the state register.
// Backpressure: none; update_req is never refused, only deferred to the next frame boundary (LOAD).
//
// Ports:
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   run             level, sampled when a frame ends (and in IDLE) to decide whether another frame follows
//   ch_enable       per-channel enable, captured into the shadow set at LOAD
//   pw_in           packed pulse widths, channel k at [k*PW_WIDTH +: PW_WIDTH], captured at LOAD
//   update_req      single-cycle request to reload the shadow set at the next LOAD
//   update_ack      single-cycle pulse in the LOAD cycle that performed a reload
//   pwm_out         servo outputs, at most one bit high at a time
//   frame_start     high in every LOAD cycle (frame cycle 0)
//   active_ch       index of the channel whose slot is current
//   busy            high whenever a frame is in progress
//   clamp_flag      some nonzero width was clamped at the last reload
module servo_pwm_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int PW_WIDTH    = 20,
    parameter int FRAME_TICKS = 2000000,
    parameter int SLOT_TICKS  = 500000,
    parameter int PW_MIN      = 50000,
    parameter int PW_MAX      = 250000
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         run,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*PW_WIDTH-1:0]   pw_in,
    input  logic                         update_req,
    output logic                         update_ack,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         frame_start,
    output logic [$clog2(NUM_CH)-1:0]    active_ch,
    output logic                         busy,
    output logic                         clamp_flag
);

    localparam int FW = $clog2(FRAME_TICKS);
    localparam int SW = $clog2(SLOT_TICKS);
    localparam int CW = $clog2(NUM_CH);
    // Frames longer than the slot train idle in TAIL until the frame period is used up.
    localparam bit HAS_TAIL = (NUM_CH * SLOT_TICKS) < FRAME_TICKS;

    localparam logic [PW_WIDTH-1:0] PW_MIN_V = PW_WIDTH'(PW_MIN);
    localparam logic [PW_WIDTH-1:0] PW_MAX_V = PW_WIDTH'(PW_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SLOT = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [FW-1:0]          frame_cnt;
    logic [SW-1:0]          slot_cnt;
    logic [CW-1:0]          slot_idx;

    logic [PW_WIDTH-1:0]    shadow_pw  [NUM_CH];
    logic [NUM_CH-1:0]      shadow_en;
    logic                   pending;

    logic [PW_WIDTH-1:0]    pw_raw     [NUM_CH];
    logic [PW_WIDTH-1:0]    pw_clamped [NUM_CH];
    logic [NUM_CH-1:0]      clamp_hit;
    logic [PW_WIDTH-1:0]    eff_pw     [NUM_CH];
    logic [NUM_CH-1:0]      pwm_nxt;

    logic                   load_now;
    logic                   last_frame_tick;
    logic                   last_slot_tick;
    logic                   last_slot;
    logic                   frame_done;
    logic                   in_slot;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    assign load_now        = (state == LOAD) && (pending || update_req);
    assign last_frame_tick = (frame_cnt == FW'(FRAME_TICKS - 1));
    assign last_slot_tick  = (slot_cnt == SW'(SLOT_TICKS - 1));
    assign last_slot       = (slot_idx == CW'(NUM_CH - 1));
    assign in_slot         = (state == LOAD) || (state == SLOT);

    assign update_ack  = load_now;
    assign frame_start = (state == LOAD);
    assign busy        = (state != IDLE);
    assign active_ch   = slot_idx;

    // ------------------------------------------------------------------
    // Width clamp, evaluated on the live inputs so LOAD can use it directly
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pw_raw[k]     = pw_in[k*PW_WIDTH +: PW_WIDTH];
            pw_clamped[k] = pw_raw[k];
            clamp_hit[k]  = 1'b0;
            if (pw_raw[k] == '0) begin
                pw_clamped[k] = '0;
            end else if (pw_raw[k] < PW_MIN_V) begin
                pw_clamped[k] = PW_MIN_V;
                clamp_hit[k]  = 1'b1;
            end else if (pw_raw[k] > PW_MAX_V) begin
                pw_clamped[k] = PW_MAX_V;
                clamp_hit[k]  = 1'b1;
            end
        end
    end

    // Effective widths for the current cycle. In a reloading LOAD cycle the
    // shadow registers still hold the old frame, but channel 0's pulse decision
    // for t=0 must already see the new value, so the clamped inputs are used.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (load_now) begin
                eff_pw[k] = ch_enable[k] ? pw_clamped[k] : '0;
            end else begin
                eff_pw[k] = shadow_en[k] ? shadow_pw[k] : '0;
            end
        end
    end

    // Pulse while the offset inside the owning slot is below the width; the
    // register stage moves the pulse to cycles [k*SLOT+1, k*SLOT+width].
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_nxt[k] = in_slot && (slot_idx == CW'(k))
                         && (32'(slot_cnt) < 32'(eff_pw[k]));
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SLOT;
            end
            SLOT: begin
                if (last_slot && last_slot_tick) begin
                    if (HAS_TAIL) begin
                        state_nxt = TAIL;
                    end else begin
                        state_nxt = run ? LOAD : IDLE;
                    end
                end
            end
            TAIL: begin
                if (last_frame_tick) begin
                    state_nxt = run ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign frame_done = ((state == SLOT) || (state == TAIL))
                        && ((state_nxt == LOAD) || (state_nxt == IDLE));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame / slot counters. LOAD is frame cycle 0 and also slot 0 offset 0,
    // so both counters sit at zero whenever the next cycle starts a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt <= '0;
            slot_cnt  <= '0;
            slot_idx  <= '0;
        end else if ((state == IDLE) || frame_done) begin
            frame_cnt <= '0;
            slot_cnt  <= '0;
            slot_idx  <= '0;
        end else begin
            frame_cnt <= frame_cnt + FW'(1);
            // In TAIL the slot position is frozen on the last channel.
            if (state != TAIL) begin
                if (last_slot_tick) begin
                    slot_cnt <= '0;
                    if (!last_slot) begin
                        slot_idx <= slot_idx + CW'(1);
                    end
                end else begin
                    slot_cnt <= slot_cnt + SW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow set, pending request, clamp status
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_pw[k] <= '0;
            end
            shadow_en  <= '0;
            clamp_flag <= 1'b0;
        end else if (load_now) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_pw[k] <= pw_clamped[k];
            end
            shadow_en  <= ch_enable;
            clamp_flag <= |clamp_hit;
        end
    end

    // A LOAD always drains the request: either it was pending/arriving and
    // got consumed, or there was none.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pending <= 1'b0;
        end else if (state == LOAD) begin
            pending <= 1'b0;
        end else if (update_req) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
`timescale 1ns/1ps
// Purpose : self-checking bench for servo_pwm_scheduler (small frame geometry).
// Latency : every cycle is compared against a frame-position reference model.
// Backpressure: n/a.
module tb_servo_pwm_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FRAME = 100;
    localparam int SLOT  = 20;
    localparam int PMIN  = 2;
    localparam int PMAX  = 15;

    logic           ACLK = 1'b0;
    logic           ARESETN = 1'b0;
    logic           run = 1'b0;
    logic           update_req = 1'b0;
    logic [N-1:0]   ch_enable = '0;
    logic [N*W-1:0] pw_in = '0;
    logic           update_ack;
    logic [N-1:0]   pwm_out;
    logic           frame_start;
    logic [1:0]     active_ch;
    logic           busy;
    logic           clamp_flag;

    servo_pwm_scheduler #(
        .NUM_CH(N), .PW_WIDTH(W), .FRAME_TICKS(FRAME),
        .SLOT_TICKS(SLOT), .PW_MIN(PMIN), .PW_MAX(PMAX)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .run(run), .ch_enable(ch_enable),
        .pw_in(pw_in), .update_req(update_req), .update_ack(update_ack),
        .pwm_out(pwm_out), .frame_start(frame_start), .active_ch(active_ch),
        .busy(busy), .clamp_flag(clamp_flag)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Values applied at the next negedge by step().
    logic         s_rstn = 1'b0;
    logic         s_run  = 1'b0;
    logic         s_req  = 1'b0;
    logic [N-1:0] s_en   = '0;
    int           s_pw [N];

    // Reference model: position in the frame (-1 = no frame running) and the
    // effective widths captured at the start of the current frame.
    int m_t = -1;
    int m_eff [N];
    bit m_pending = 1'b0;
    bit m_clamp = 1'b0;

    int meas_w [N];
    int meas_rise [N];
    int meas_ack;
    int meas_fs;

    typedef struct packed {
        logic [N-1:0][7:0] pw;
        logic [N-1:0]      en;
        logic [N-1:0][7:0] w;
        logic              clamp;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(int p0, int p1, int p2, int p3, logic [N-1:0] en,
                                int w0, int w1, int w2, int w3, logic cl);
        vec_t v;
        v.pw[0] = 8'(p0); v.pw[1] = 8'(p1); v.pw[2] = 8'(p2); v.pw[3] = 8'(p3);
        v.w[0]  = 8'(w0); v.w[1]  = 8'(w1); v.w[2]  = 8'(w2); v.w[3]  = 8'(w3);
        v.en    = en;
        v.clamp = cl;
        return v;
    endfunction

    function automatic int clampv(int v);
        if (v == 0)   return 0;
        if (v < PMIN) return PMIN;
        if (v > PMAX) return PMAX;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d, model t=%0d): got %0d, expected %0d",
                     name, cyc, m_t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t       = -1;
        m_pending = 1'b0;
        m_clamp   = 1'b0;
        for (int k = 0; k < N; k++) m_eff[k] = 0;
    endtask

    task automatic check_cycle();
        int exp_pwm;
        exp_pwm = 0;
        for (int k = 0; k < N; k++) begin
            if (m_t >= k*SLOT + 1 && m_t <= k*SLOT + m_eff[k]) exp_pwm |= (1 << k);
        end
        check("pwm_out",     int'(pwm_out),     exp_pwm);
        check("frame_start", int'(frame_start), int'(m_t == 0));
        check("update_ack",  int'(update_ack),  int'(m_t == 0 && (m_pending || update_req)));
        check("busy",        int'(busy),        int'(m_t >= 0));
        check("clamp_flag",  int'(clamp_flag),  int'(m_clamp));
        if (m_t >= 0 && m_t < N*SLOT) check("active_ch", int'(active_ch), m_t / SLOT);
    endtask

    task automatic model_advance();
        int v;
        if (m_t == 0) begin
            if (m_pending || update_req) begin
                m_clamp = 1'b0;
                for (int k = 0; k < N; k++) begin
                    v = int'(pw_in[k*W +: W]);
                    m_eff[k] = ch_enable[k] ? clampv(v) : 0;
                    if (v != 0 && clampv(v) != v) m_clamp = 1'b1;
                end
                m_pending = 1'b0;
            end
        end else if (update_req) begin
            m_pending = 1'b1;
        end
        if (m_t < 0 || m_t == FRAME - 1) m_t = run ? 0 : -1;
        else                             m_t++;
    endtask

    // One clock cycle: drive at negedge, compare 1 time unit later, then let
    // the model take the coming posedge.
    task automatic step();
        @(negedge ACLK);
        ARESETN    = s_rstn;
        run        = s_run;
        ch_enable  = s_en;
        update_req = s_req;
        for (int k = 0; k < N; k++) pw_in[k*W +: W] = W'(s_pw[k]);
        s_req = 1'b0;
        #1;
        if (!s_rstn) model_reset();
        check_cycle();
        if (s_rstn) model_advance();
        cyc++;
    endtask

    task automatic goto_t(input int t);
        int n;
        n = 0;
        while (m_t != t && n < 400) begin
            step();
            n++;
        end
        check("goto_t reached", m_t, t);
    endtask

    // Runs one whole frame starting at its LOAD cycle; optionally raises
    // update_req (with a new channel-0 width) at frame cycle req_at.
    task automatic measure_frame(input int req_at, input int pw0);
        goto_t(0);
        meas_ack = 0;
        meas_fs  = 0;
        for (int k = 0; k < N; k++) begin
            meas_w[k]    = 0;
            meas_rise[k] = -1;
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c == req_at) begin
                s_req    = 1'b1;
                s_pw[0]  = pw0;
            end
            step();
            meas_ack += int'(update_ack);
            meas_fs  += int'(frame_start);
            for (int k = 0; k < N; k++) begin
                if (pwm_out[k]) begin
                    meas_w[k]++;
                    if (meas_rise[k] < 0) meas_rise[k] = c;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fs;

        vecs[0] = mk(10,  5,  8,  3, 4'b1111, 10,  5,  8,  3, 1'b0);
        vecs[1] = mk( 1, 20,  0, 15, 4'b1111,  2, 15,  0, 15, 1'b1);
        vecs[2] = mk( 4,  4,  4,  4, 4'b1111,  4,  4,  4,  4, 1'b0);
        vecs[3] = mk(10,  5,  8,  3, 4'b1010,  0,  5,  0,  3, 1'b0);
        vecs[4] = mk( 2, 16, 14,  0, 4'b1111,  2, 15, 14,  0, 1'b1);
        vecs[5] = mk( 0,  0,  0,  0, 4'b1111,  0,  0,  0,  0, 1'b0);
        vecs[6] = mk(255, 1, 15,  2, 4'b0111, 15,  2, 15,  0, 1'b1);
        for (int k = 0; k < N; k++) s_pw[k] = 0;

        // Reset state
        step();
        step();
        check("reset pwm_out",     int'(pwm_out), 0);
        check("reset busy",        int'(busy), 0);
        check("reset frame_start", int'(frame_start), 0);
        check("reset update_ack",  int'(update_ack), 0);
        check("reset active_ch",   int'(active_ch), 0);
        check("reset clamp_flag",  int'(clamp_flag), 0);
        s_rstn = 1'b1;
        step();

        // Table: each vector is requested, then its frame is measured.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < N; k++) s_pw[k] = int'(vecs[i].pw[k]);
            s_en = vecs[i].en;
            if (i == 0) begin
                // request while IDLE, held until the first LOAD
                s_req = 1'b1;
                step();
                s_run = 1'b1;
            end else begin
                goto_t(50);
                s_req = 1'b1;
                step();
            end
            measure_frame(-1, 0);
            for (int k = 0; k < N; k++) begin
                check($sformatf("vec%0d width ch%0d", i, k), meas_w[k], int'(vecs[i].w[k]));
                check($sformatf("vec%0d rise ch%0d", i, k), meas_rise[k],
                      (vecs[i].w[k] != 0) ? k*SLOT + 1 : -1);
            end
            check($sformatf("vec%0d clamp_flag", i), int'(clamp_flag), int'(vecs[i].clamp));
            check($sformatf("vec%0d acks", i), meas_ack, 1);
            check($sformatf("vec%0d frame_starts", i), meas_fs, 1);
        end

        // Glitch-free update mid-pulse
        s_en = 4'b1111;
        s_pw[0] = 10; s_pw[1] = 5; s_pw[2] = 8; s_pw[3] = 3;
        goto_t(50);
        s_req = 1'b1;
        step();
        measure_frame(-1, 10);
        check("glitch base width", meas_w[0], 10);
        measure_frame(5, 3);
        check("glitch in-flight width", meas_w[0], 10);
        check("glitch in-flight acks", meas_ack, 0);
        measure_frame(-1, 3);
        check("glitch next width", meas_w[0], 3);
        check("glitch next acks", meas_ack, 1);

        // Several requests collapse into one ack; a LOAD-cycle request is used at once
        goto_t(30); s_req = 1'b1; step();
        goto_t(45); s_req = 1'b1; step();
        goto_t(80); s_req = 1'b1; step();
        measure_frame(-1, 3);
        check("collapsed acks", meas_ack, 1);
        measure_frame(0, 7);
        check("load-cycle req acks", meas_ack, 1);
        check("load-cycle req width", meas_w[0], 7);
        measure_frame(-1, 7);
        check("no-req acks", meas_ack, 0);

        // run=0 mid-frame: frame completes, then IDLE
        goto_t(30);
        s_run = 1'b0;
        step();
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("busy drop after run=0", n, 70);
        fs = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            fs += int'(frame_start);
        end
        check("no frame_start in IDLE", fs, 0);
        s_run = 1'b1;
        measure_frame(-1, 7);
        check("restart frame_starts", meas_fs, 1);

        // Asynchronous reset in the middle of channel 1's pulse
        goto_t(22);
        check("pre-reset pwm_out[1]", int'(pwm_out[1]), 1);
        s_rstn = 1'b0;
        step();
        check("mid-reset pwm_out",    int'(pwm_out), 0);
        check("mid-reset busy",       int'(busy), 0);
        check("mid-reset clamp_flag", int'(clamp_flag), 0);
        s_rstn = 1'b1;
        step();
        check("release cycle frame_start", int'(frame_start), 0);
        step();
        check("first frame_start after reset", int'(frame_start), 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (!s_rstn) s_rstn = 1'b1;
            else if ($urandom_range(999) < 2) s_rstn = 1'b0;
            if ($urandom_range(99) < 4) s_req = 1'b1;
            if ($urandom_range(99) < 3) begin
                for (int k = 0; k < N; k++) begin
                    s_pw[k] = ($urandom_range(9) == 0) ? int'($urandom_range(255))
                                                       : int'($urandom_range(20));
                end
                s_en = 4'($urandom_range(15));
            end
            if ($urandom_range(999) < 5) s_run = ~s_run;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_scheduler.md
Name: servo_pwm_scheduler

Overview:
Time-multiplexed PWM sequencer for the servo IP. It sits behind the AXI4-Lite slave register bank and drives NUM_CH servo outputs from a single frame/slot counter pair. Channels are pulsed one after another inside a fixed frame. Pulse widths and enables are shadow-loaded only at frame boundaries, so register writes from software never glitch a pulse in flight.

Parameters:
NUM_CH, 4, number of servo channels (2..8)
PW_WIDTH, 20, width of each pulse-width field in ACLK cycles
FRAME_TICKS, 2000000, frame period in cycles (20 ms at 100 MHz); must satisfy NUM_CH*SLOT_TICKS <= FRAME_TICKS
SLOT_TICKS, 500000, slot length per channel in cycles
PW_MIN, 50000, lower clamp for nonzero widths
PW_MAX, 250000, upper clamp for widths; must be < SLOT_TICKS

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
run  in  1  level; 1 = generate frames
ch_enable  in  NUM_CH  per-channel enable, sampled at LOAD
pw_in  in  NUM_CH*PW_WIDTH  packed widths, channel k at [k*PW_WIDTH +: PW_WIDTH], sampled at LOAD
update_req  in  1  one-cycle pulse: request shadow reload at next LOAD
update_ack  out  1  one-cycle pulse in the LOAD cycle that consumed a pending request
pwm_out  out  NUM_CH  servo pulse outputs, registered
frame_start  out  1  one-cycle pulse in every LOAD cycle
active_ch  out  clog2(NUM_CH)  index of the channel whose slot is current
busy  out  1  high in every state except IDLE
clamp_flag  out  1  set if any width was clamped at the last reload; held until the next reload

Behaviour:
- Reset (async, ARESETN=0): state=IDLE; counters=0; shadows=0; pending=0; all outputs 0. This takes effect immediately mid-frame; no pulse completes.
- FSM states: IDLE, LOAD, SLOT, TAIL.
- IDLE: run=1 -> LOAD on the next cycle.
- LOAD: lasts 1 cycle and is frame cycle t=0.
  - frame_start=1.
  - If pending or update_req: shadow_pw <= clamp(pw_in); shadow_en <= ch_enable; update_ack=1; pending cleared; clamp_flag updated.
  - LOAD -> SLOT.
- Frame counter t runs 0..FRAME_TICKS-1. Slot k covers t in [k*SLOT_TICKS, (k+1)*SLOT_TICKS-1]. active_ch = k.
- SLOT ends after the last cycle of slot NUM_CH-1.
  - Goes to TAIL if NUM_CH*SLOT_TICKS < FRAME_TICKS.
  - Otherwise, at the frame end, goes to LOAD (run=1) or IDLE (run=0).
- TAIL: waits until t=FRAME_TICKS-1, then LOAD (run=1) or IDLE (run=0).
- Frame length is exactly FRAME_TICKS cycles, back-to-back with no gap.
- run=0 mid-frame: the current frame completes normally, then IDLE. run is sampled only at frame end.
- pwm_out[k]:
  - 1-cycle register latency: rises in cycle t = k*SLOT_TICKS+1.
  - Stays high exactly pw_eff[k] cycles.
  - Only one bit of pwm_out is ever high at a time.
- pw_eff[k] is 0 when shadow_en[k]=0 or shadow_pw[k]=0; a 0 width produces no pulse.
- Clamp, per channel, applied at LOAD:
  - 0 -> 0.
  - 0 < v < PW_MIN -> PW_MIN.
  - v > PW_MAX -> PW_MAX.
  - Else v.
  - clamp_flag = OR of the clamp events among nonzero inputs.
- update_req handling:
  - A request arriving in any non-LOAD cycle sets pending.
  - Multiple requests before a LOAD collapse into one ack.
  - A request in the LOAD cycle itself is consumed in that same cycle.
  - A request while IDLE is held until the first LOAD.
- Counter widths: frame counter clog2(FRAME_TICKS), slot counter clog2(SLOT_TICKS). Comparisons are unsigned. There is no wrap inside a frame.

Test Plan:
Sim parameters for all scenarios: FRAME_TICKS=100, SLOT_TICKS=20, PW_MIN=2, PW_MAX=15, NUM_CH=4.
1. Reset then run=1, pw_in={10,5,8,3}, all enabled, update_req pulse -> frame_start every 100 cycles. pwm_out[0] high for cycles 1-10, [1] for 21-25, [2] for 41-48, [3] for 61-63. update_ack is a single pulse at the first LOAD.
2. Clamp: pw_in={1,20,0,15} -> widths 2, 15, 0 (no pulse), 15; clamp_flag=1. Next reload with {4,4,4,4} -> clamp_flag=0.
3. Glitch-free update: change pw_in[0] 10->3 with update_req at t=5 mid-pulse -> current pulse stays 10 cycles; next frame's pulse is 3 cycles, with update_ack at that LOAD.
4. Enable masking: ch_enable=4'b1010 -> only pwm_out[1] and pwm_out[3] pulse; active_ch still steps 0,1,2,3 at t=0,20,40,60.
5. run=0 at t=30 -> frame runs to t=99, then IDLE; busy drops the cycle after the last frame cycle; no further frame_start.
6. ARESETN low at t=22 while pwm_out[1] is high -> all outputs 0 immediately. After release with run=1, the first frame_start occurs 2 cycles later (IDLE->LOAD).
